mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL expose parameter MULT_CYCLES, default 5, meaning the number of cycles busy stays high for mult/multu.
REQ-002 The block SHALL expose parameter DIV_CYCLES, default 10, meaning the number of cycles busy stays high for div/divu.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port srcA, input, 32 bits: rs operand, i.e. the dividend, the multiplicand, or the mthi/mtlo data.
REQ-006 The block SHALL have port srcB, input, 32 bits: rt operand, i.e. the divisor or the multiplier.
REQ-007 The block SHALL have port MDUop, input, 4 bits, operation select: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo; other codes are treated as none.
REQ-008 The block SHALL have port start, input, 1 bit, single-cycle request qualifying MDUop.
REQ-009 The block SHALL have port busy, output, 1 bit, high while an operation is in flight.
REQ-010 The block SHALL have port HI, output, 32 bits, architectural HI register.
REQ-011 The block SHALL have port LO, output, 32 bits, architectural LO register.

Function
REQ-012 States SHALL be IDLE and RUN; a down-counter of width ceil(log2(DIV_CYCLES+1)) SHALL track the remaining cycles.
REQ-013 In IDLE, start=1 with MDUop in {mult, multu, div, divu} SHALL latch srcA, srcB and the op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN at that edge.
REQ-014 busy SHALL be registered: it goes high the cycle after acceptance and stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-015 In RUN, the counter SHALL decrement each edge; at the edge where it reaches 0, HI/LO SHALL update, busy SHALL fall, and the state SHALL return to IDLE.
REQ-016 mult SHALL compute the signed 32x32 product to 64 bits, with HI = product[63:32] and LO = product[31:0].
REQ-017 multu SHALL compute the same split as mult, using unsigned operands.
REQ-018 div SHALL give LO = signed quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-019 divu SHALL give LO and HI as the unsigned quotient and unsigned remainder.
REQ-020 div with srcA=0x80000000 and srcB=0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0x00000000.
REQ-021 A divisor of 0 (div or divu) SHALL still run DIV_CYCLES cycles with busy asserted, and SHALL leave HI and LO unchanged at completion.
REQ-022 start=1 with mthi (mtlo) while IDLE SHALL write srcA into HI (LO) at the next edge, without asserting busy; the other register is unchanged.
REQ-023 start and MDUop SHALL be ignored while busy=1; the in-flight operation and its latched operands are unaffected by input changes.
REQ-024 HI and LO SHALL hold their previous values throughout RUN and change only as given in REQ-015 and REQ-022.
REQ-025 start=1 with MDUop=none or an undefined code SHALL have no effect.
REQ-026 In the cycle busy falls, a new start SHALL be accepted at that same edge only if it is presented while state is IDLE; back-to-back issue therefore leaves at least one IDLE cycle between operations.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state=IDLE, counter=0, busy=0, HI=0x00000000 and LO=0x00000000.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no HI/LO write, and the block SHALL accept start on the first edge after reset_n rises.

Verification
REQ-029 mult with srcA=0xFFFFFFFE (-2), srcB=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 multu with srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 div with srcA=0xFFFFFFF9 (-7), srcB=2 -> busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with srcA=7, srcB=0 -> HI/LO retain their prior values.
REQ-032 mthi with srcA=0x12345678 -> HI=0x12345678 next cycle and busy stays 0. mtlo presented during a running mult -> ignored; LO ends as the product low word.
REQ-033 reset_n pulsed low on cycle 3 of a div -> busy=0 and HI=LO=0 immediately; a following mult completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Operands are latched on acceptance; the result lands in HI/LO when the countdown expires.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [3:0]  MDUop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            busy_n;
    logic [31:0]     hi_n, lo_n;
    logic            load;
    logic [3:0]      op_q;
    logic [31:0]     a_q, b_q;
    logic [63:0]     mul_res, div_res;

    function automatic logic [63:0] mul_calc(input logic is_signed,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        sa = is_signed ? $signed({{32{a[31]}}, a}) : $signed({32'd0, a});
        sb = is_signed ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
        p  = sa * sb;
        return p;
    endfunction

    // Signed division goes through magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    function automatic logic [63:0] div_calc(input logic is_signed,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        logic        neg_q, neg_r;
        neg_r = is_signed & a[31];
        neg_q = is_signed & (a[31] ^ b[31]);
        ua    = neg_r ? (~a + 32'd1) : a;
        ub    = (is_signed & b[31]) ? (~b + 32'd1) : b;
        if (ub == 32'd0)
            ub = 32'd1;
        q = ua / ub;
        r = ua % ub;
        if (neg_q)
            q = ~q + 32'd1;
        if (neg_r)
            r = ~r + 32'd1;
        return {r, q};
    endfunction

    assign mul_res = mul_calc(op_q == OP_MULT, a_q, b_q);
    assign div_res = div_calc(op_q == OP_DIV, a_q, b_q);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy_n  = busy;
        hi_n    = HI;
        lo_n    = LO;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (MDUop)
                        OP_MULT, OP_MULTU: begin
                            load    = 1'b1;
                            state_n = RUN;
                            cnt_n   = CW'(MULT_CYCLES);
                            busy_n  = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            load    = 1'b1;
                            state_n = RUN;
                            cnt_n   = CW'(DIV_CYCLES);
                            busy_n  = 1'b1;
                        end
                        OP_MTHI: hi_n = srcA;
                        OP_MTLO: lo_n = srcA;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    // A zero divisor completes silently, leaving HI/LO untouched.
                    if (op_q == OP_MULT || op_q == OP_MULTU)
                        {hi_n, lo_n} = mul_res;
                    else if (b_q != 32'd0)
                        {hi_n, lo_n} = div_res;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            HI    <= hi_n;
            LO    <= lo_n;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            op_q <= MDUop;
            a_q  <= srcA;
            b_q  <= srcB;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic results, busy timing, mthi/mtlo,
// ignored requests, back-to-back issue and mid-operation reset.
module tb_mul_div_unit;

    localparam logic [3:0] OP_NONE  = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] srcA, srcB;
    logic [3:0]  MDUop;
    logic        start;
    logic        busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .srcA(srcA), .srcB(srcB),
        .MDUop(MDUop), .start(start), .busy(busy), .HI(HI), .LO(LO)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        srcA  = a;
        srcB  = b;
        MDUop = op;
        start = 1'b1;
        step();
        start = 1'b0;
        MDUop = OP_NONE;
    endtask

    task automatic run_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; MDUop = OP_NONE; srcA = 32'd0; srcB = 32'd0;
        step(); step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=00000000", HI); end
        total++; if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=00000000", LO); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_mult();
        int n;
        logic held;
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mult_busy_rise got=%b exp=1", busy); end
        n = 0; held = 1'b1;
        while (busy === 1'b1 && n < 60) begin
            if (HI !== 32'd0 || LO !== 32'd0) held = 1'b0;
            n++;
            step();
        end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL mult_hold_during_run got=%b exp=1", held); end
        total++; if (n != 5) begin bad++; $display("FAIL mult_busy_len got=%0d exp=5", n); end
        total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
        total++; if (LO !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffa", LO); end
    endtask

    task automatic test_multu();
        int n;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_len(n);
        total++; if (n != 5) begin bad++; $display("FAIL multu_busy_len got=%0d exp=5", n); end
        total++; if (HI !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", HI); end
        total++; if (LO !== 32'h00000001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", LO); end
    endtask

    task automatic test_div();
        int n;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        run_len(n);
        total++; if (n != 10) begin bad++; $display("FAIL div_busy_len got=%0d exp=10", n); end
        total++; if (LO !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
        total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
        issue(OP_DIVU, 32'd100, 32'd7);
        run_len(n);
        total++; if (LO !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h exp=0000000e", LO); end
        total++; if (HI !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h exp=00000002", HI); end
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        run_len(n);
    endtask

    task automatic test_div_by_zero();
        int n;
        issue(OP_DIVU, 32'd7, 32'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL divzero_busy got=%b exp=1", busy); end
        run_len(n);
        total++; if (n != 10) begin bad++; $display("FAIL divzero_busy_len got=%0d exp=10", n); end
        total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL divzero_hi got=%h exp=ffffffff", HI); end
        total++; if (LO !== 32'hFFFFFFFD) begin bad++; $display("FAIL divzero_lo got=%h exp=fffffffd", LO); end
    endtask

    task automatic test_div_overflow();
        int n;
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_len(n);
        total++; if (LO !== 32'h80000000) begin bad++; $display("FAIL divovf_lo got=%h exp=80000000", LO); end
        total++; if (HI !== 32'h00000000) begin bad++; $display("FAIL divovf_hi got=%h exp=00000000", HI); end
    endtask

    task automatic test_mthi_mtlo();
        issue(OP_MTHI, 32'h12345678, 32'd0);
        total++; if (HI !== 32'h12345678) begin bad++; $display("FAIL mthi_hi got=%h exp=12345678", HI); end
        total++; if (LO !== 32'h80000000) begin bad++; $display("FAIL mthi_lo_kept got=%h exp=80000000", LO); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        issue(OP_MTLO, 32'hCAFEF00D, 32'd0);
        total++; if (LO !== 32'hCAFEF00D) begin bad++; $display("FAIL mtlo_lo got=%h exp=cafef00d", LO); end
        total++; if (HI !== 32'h12345678) begin bad++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", HI); end
    endtask

    task automatic test_none();
        issue(OP_NONE, 32'hBAD0BAD0, 32'd1);
        issue(4'b1111, 32'hBAD0BAD0, 32'd1);
        issue(4'b0111, 32'hBAD0BAD0, 32'd1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL none_busy got=%b exp=0", busy); end
        total++; if (HI !== 32'h12345678) begin bad++; $display("FAIL none_hi got=%h exp=12345678", HI); end
        total++; if (LO !== 32'hCAFEF00D) begin bad++; $display("FAIL none_lo got=%h exp=cafef00d", LO); end
    endtask

    task automatic test_ignored_while_busy();
        int n;
        issue(OP_MULT, 32'd6, 32'd7);
        srcA = 32'hDEADBEEF; srcB = 32'd1; MDUop = OP_MTLO; start = 1'b1;
        step();
        MDUop = OP_DIV;
        step();
        start = 1'b0; MDUop = OP_NONE;
        run_len(n);
        total++; if (n + 2 != 5) begin bad++; $display("FAIL ignore_busy_len got=%0d exp=5", n + 2); end
        total++; if (LO !== 32'd42) begin bad++; $display("FAIL ignore_lo got=%h exp=0000002a", LO); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL ignore_hi got=%h exp=00000000", HI); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(OP_MULT, 32'd2, 32'd3);
        srcA = 32'd5; srcB = 32'd5; MDUop = OP_MULT; start = 1'b1;
        run_len(n);
        total++; if (n != 5) begin bad++; $display("FAIL b2b_first_len got=%0d exp=5", n); end
        total++; if (LO !== 32'd6) begin bad++; $display("FAIL b2b_first_lo got=%h exp=00000006", LO); end
        step();
        start = 1'b0; MDUop = OP_NONE;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got=%b exp=1", busy); end
        run_len(n);
        total++; if (n != 5) begin bad++; $display("FAIL b2b_second_len got=%0d exp=5", n); end
        total++; if (LO !== 32'd25) begin bad++; $display("FAIL b2b_second_lo got=%h exp=00000019", LO); end
    endtask

    task automatic test_reset_mid_op();
        int n;
        issue(OP_MTHI, 32'h55AA55AA, 32'd0);
        issue(OP_DIV, 32'd100, 32'd7);
        step(); step();
        #2 reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL rstmid_hi got=%h exp=00000000", HI); end
        total++; if (LO !== 32'd0) begin bad++; $display("FAIL rstmid_lo got=%h exp=00000000", LO); end
        step();
        reset_n = 1'b1;
        issue(OP_MULT, 32'd3, 32'd4);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_accept got=%b exp=1", busy); end
        run_len(n);
        total++; if (n != 5) begin bad++; $display("FAIL rstmid_mult_len got=%0d exp=5", n); end
        total++; if (LO !== 32'd12) begin bad++; $display("FAIL rstmid_mult_lo got=%h exp=0000000c", LO); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL rstmid_mult_hi got=%h exp=00000000", HI); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_by_zero();
        test_div_overflow();
        test_mthi_mtlo();
        test_none();
        test_ignored_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
